// File: rtl/ac_pkg.sv
// Shared types and constants for the arithmetic-coding frame sequencer.
package ac_pkg;

  localparam int unsigned SYM_W  = 3;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned WDOG_W = 16;

  localparam int unsigned SYMS_PER_FRAME_DEF = 96;
  localparam int unsigned TIMEOUT_CYC_DEF    = 255;

  localparam logic [SYM_W-1:0] SYM_M1  = 3'b101;
  localparam logic [SYM_W-1:0] SYM_0   = 3'b000;
  localparam logic [SYM_W-1:0] SYM_1   = 3'b001;
  localparam logic [SYM_W-1:0] SYM_2   = 3'b010;
  localparam logic [SYM_W-1:0] SYM_3   = 3'b011;
  localparam logic [SYM_W-1:0] SYM_EOF = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_FLUSH,
    ST_WAIT_FL,
    ST_DONE,
    ST_ERR
  } ac_state_e;

  // One beat on the core-side symbol bus.
  typedef struct packed {
    logic             last;
    logic [SYM_W-1:0] sym;
  } ac_beat_t;

  function automatic logic ac_sym_legal(input logic [SYM_W-1:0] code);
    case (code)
      SYM_M1, SYM_0, SYM_1, SYM_2, SYM_3, SYM_EOF: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ac_wdog.sv
// Stall watchdog: load/clear/enable counter that trips on the TIMEOUT_CYC-th
// consecutive enabled cycle.
module ac_wdog
  import ac_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              ld,
  input  logic [WDOG_W-1:0] ld_val,
  input  logic              en,
  output logic              trip
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  // Saturating count; clear has priority over load.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      cnt_d = ld_val;
    end else if (en && (cnt_q < WDOG_W'(TIMEOUT_CYC))) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign trip = en && !clr && !ld && (cnt_q >= WDOG_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ac_frame_ctrl.sv
// Frame sequencer feeding SYMS_PER_FRAME symbols into the AC encoder core, then
// flushing it. Define AC_FRAME_CTRL_SYMCHK_EN to drop and flag illegal codes.
module ac_frame_ctrl
  import ac_pkg::*;
#(
  parameter int unsigned SYMS_PER_FRAME = SYMS_PER_FRAME_DEF,
  parameter int unsigned TIMEOUT_CYC    = TIMEOUT_CYC_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  input  logic             frame_start,
  input  logic             frame_abort,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic [SYM_W-1:0] core_sym,
  output logic             core_valid,
  input  logic             core_ready,
  output logic             core_last,
  output logic             core_flush,
  input  logic             core_flush_done,
  output logic             frame_busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] sym_count,
  output logic             err_timeout,
  output logic             err_illegal
);

  ac_state_e        state_q, state_d;
  ac_beat_t         beat_q, beat_d;
  logic             core_valid_q, core_valid_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] sym_count_q, sym_count_d;
  logic             flush_q, flush_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             err_to_q, err_to_d;
  logic             err_il_q, err_il_d;

  logic up_xfer, core_xfer, sym_ok, sym_load, sym_drop, acc_last;
  logic stall, wd_clr, wd_trip;

  assign sym_ready = (state_q == ST_FEED) && (!core_valid_q || core_ready) &&
                     (acc_cnt_q < CNT_W'(SYMS_PER_FRAME));
  assign up_xfer   = sym_valid && sym_ready;
  assign core_xfer = (state_q == ST_FEED) && core_valid_q && core_ready;

`ifdef AC_FRAME_CTRL_SYMCHK_EN
  assign sym_ok = ac_sym_legal(sym_in);
`else
  assign sym_ok = 1'b1;
`endif

  assign sym_load = up_xfer && sym_ok;
  assign sym_drop = up_xfer && !sym_ok;
  assign acc_last = (acc_cnt_q + CNT_W'(1)) == CNT_W'(SYMS_PER_FRAME);

  assign stall  = ((state_q == ST_FEED) && core_valid_q && !core_ready) ||
                  ((state_q == ST_DRAIN) && !core_ready) ||
                  ((state_q == ST_WAIT_FL) && !core_flush_done);
  assign wd_clr = frame_abort || (state_q == ST_IDLE);

  ac_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk   (sys_clk),
    .rst_n (sys_reset),
    .clr   (wd_clr),
    .ld    (!stall),
    .ld_val('0),
    .en    (stall),
    .trip  (wd_trip)
  );

  // Next state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    core_valid_d = core_valid_q;
    acc_cnt_d    = acc_cnt_q;
    sym_count_d  = sym_count_q;
    err_to_d     = err_to_q;
    err_il_d     = err_il_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d      = ST_FEED;
          acc_cnt_d    = '0;
          sym_count_d  = '0;
          core_valid_d = 1'b0;
          beat_d.last  = 1'b0;
        end
      end
      ST_FEED: begin
        if (core_xfer) begin
          core_valid_d = 1'b0;
          beat_d.last  = 1'b0;
          if (sym_count_q < CNT_W'(SYMS_PER_FRAME)) begin
            sym_count_d = sym_count_q + CNT_W'(1);
          end
          if (beat_q.last) begin
            state_d = ST_DRAIN;
          end
        end
        if (sym_load) begin
          beat_d       = '{last: acc_last, sym: sym_in};
          core_valid_d = 1'b1;
          acc_cnt_d    = acc_cnt_q + CNT_W'(1);
        end
        if (sym_drop) begin
          err_il_d = 1'b1;
        end
        if (wd_trip) begin
          state_d      = ST_ERR;
          err_to_d     = 1'b1;
          core_valid_d = 1'b0;
          beat_d.last  = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (core_ready) begin
          state_d = ST_FLUSH;
        end else if (wd_trip) begin
          state_d  = ST_ERR;
          err_to_d = 1'b1;
        end
      end
      ST_FLUSH: state_d = ST_WAIT_FL;
      ST_WAIT_FL: begin
        if (core_flush_done) begin
          state_d = ST_DONE;
        end else if (wd_trip) begin
          state_d  = ST_ERR;
          err_to_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including a load in the same cycle.
    if (frame_abort) begin
      state_d      = ST_IDLE;
      beat_d       = '{last: 1'b0, sym: beat_q.sym};
      core_valid_d = 1'b0;
      acc_cnt_d    = '0;
      sym_count_d  = '0;
      err_to_d     = 1'b0;
      err_il_d     = 1'b0;
    end

    flush_d = (state_d == ST_FLUSH);
    done_d  = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE) && (state_d != ST_ERR);
  end

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      core_valid_q <= 1'b0;
      acc_cnt_q    <= '0;
      sym_count_q  <= '0;
      flush_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_to_q     <= 1'b0;
      err_il_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      core_valid_q <= core_valid_d;
      acc_cnt_q    <= acc_cnt_d;
      sym_count_q  <= sym_count_d;
      flush_q      <= flush_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      err_to_q     <= err_to_d;
      err_il_q     <= err_il_d;
    end
  end

  assign core_sym    = beat_q.sym;
  assign core_last   = beat_q.last;
  assign core_valid  = core_valid_q;
  assign core_flush  = flush_q;
  assign frame_done  = done_q;
  assign frame_busy  = busy_q;
  assign sym_count   = sym_count_q;
  assign err_timeout = err_to_q;
  assign err_illegal = err_il_q;

endmodule

// File: doc/ac_frame_ctrl.md
# ac_frame_ctrl

Frame sequencer for the arithmetic-coding encoder core. Accepts 3-bit quantised symbols from the upstream channel stream and feeds exactly `SYMS_PER_FRAME` of them per frame into the core over a valid/ready handshake. Then requests core termination (flush) and waits for completion before reporting the frame done. A watchdog guards against a stalled core, and an abort returns the block to idle from any state.

## Interface
- `SYMS_PER_FRAME`, 96: symbols per frame; legal range 1..127.
- `TIMEOUT_CYC`, 255: stall cycles before watchdog trip; legal range 1..65535.
- `sys_clk` in 1: single clock, rising edge.
- `sys_reset` in 1: asynchronous, active-low reset.
- `frame_start` in 1: 1-cycle pulse; starts a frame when idle.
- `frame_abort` in 1: synchronous abort from any state.
- `sym_in` in 3: upstream symbol code.
- `sym_valid` in 1: upstream symbol valid.
- `sym_ready` out 1: block accepts `sym_in` this cycle.
- `core_sym` out 3: symbol to the core, registered.
- `core_valid` out 1: `core_sym` valid.
- `core_ready` in 1: core accepts a symbol; high only when the core has finished renormalising.
- `core_last` out 1: qualifies the final symbol of the frame.
- `core_flush` out 1: 1-cycle termination request.
- `core_flush_done` in 1: core has emitted all termination bits.
- `frame_busy` out 1: high in any state except IDLE and ERR.
- `frame_done` out 1: 1-cycle pulse at frame completion.
- `sym_count` out 7: count of symbols transferred to the core in the current frame.
- `err_timeout` out 1: sticky watchdog flag.
- `err_illegal` out 1: sticky illegal-symbol flag.

## Operation
- States: IDLE, FEED, DRAIN, FLUSH, WAIT_FL, DONE, ERR.
- **IDLE**
  - On `frame_start`, go to FEED.
  - Clear `sym_count`, the accept counter and the watchdog.
- **FEED**
  - `sym_ready = !core_valid || core_ready`, gated off once the accept counter reaches `SYMS_PER_FRAME`.
  - An upstream transfer (`sym_valid && sym_ready`) loads `core_sym`, sets `core_valid` and increments the accept counter.
  - `core_last` is set with the symbol when it is the `SYMS_PER_FRAME`-th accepted symbol.
  - A core transfer (`core_valid && core_ready`) increments `sym_count` and clears `core_valid`, unless a new symbol is loaded in the same cycle.
  - When the core transfer of the last symbol occurs, go to DRAIN.
- **DRAIN**: wait for `core_ready` = 1 (the core has finished renormalising the last symbol), then go to FLUSH.
- **FLUSH**: assert `core_flush` for exactly one cycle, then go to WAIT_FL.
- **WAIT_FL**: on `core_flush_done`, go to DONE.
- **DONE**: assert `frame_done` for one cycle, then go to IDLE. `sym_count` holds its value until the next `frame_start`.
- **Watchdog**
  - Counts cycles while (FEED with `core_valid && !core_ready`), DRAIN or WAIT_FL. Resets on any progress event.
  - On reaching `TIMEOUT_CYC`: set `err_timeout` and go to ERR.
- **ERR**
  - `core_valid`, `sym_ready` and `core_flush` are 0.
  - Leaves only on `frame_abort`.
- **`frame_abort`**
  - From any state, go to IDLE next cycle.
  - Clears `core_valid`, the counters and both error flags.
- **Precedence**
  - `frame_abort` overrides every other event.
  - `frame_start` outside IDLE is ignored.
  - `frame_start` together with `frame_abort` leaves the block in IDLE.
- **Arithmetic**
  - Counters are unsigned, 7 bits; the watchdog is 16 bits.
  - Counters never wrap: increments are gated at `SYMS_PER_FRAME` and `TIMEOUT_CYC`.

## Timing
- Reset values of outputs:
  - All outputs are 0 and the state is IDLE.
  - `core_sym` = 3'b000.
- Latency:
  - Upstream accept to `core_valid`: 1 cycle.
  - Throughput is 1 symbol per cycle when `core_ready` stays high.
- `sym_ready` is combinational from `core_valid`, `core_ready` and the state; it is not combinational from `sym_valid`.
- Last core transfer to `core_flush`: at least 2 cycles (DRAIN then FLUSH).
- `core_flush_done` to `frame_done`: 1 cycle.
- Reset asserted mid-frame returns all state asynchronously to reset values; the core is reset by the same `sys_reset`.

## Configuration
- Macro: `AC_FRAME_CTRL_SYMCHK_EN`.
- Defined:
  - Legal codes are 101, 000, 001, 010, 011, 111.
  - An accepted 100 or 110 is dropped: it is not forwarded, not counted and does not set `core_last`.
  - A dropped symbol sets `err_illegal`; the frame continues.
- Undefined:
  - All codes are forwarded unchanged.
  - `err_illegal` is tied to 0.

## Structure
- Package `ac_pkg` holds:
  - Symbol code constants (SYM_M1=101, SYM_0=000, SYM_1=001, SYM_2=010, SYM_3=011, SYM_EOF=111).
  - The state enum.
  - A function `ac_sym_legal(code)`.
  - The default `SYMS_PER_FRAME` and `TIMEOUT_CYC`.
- One sub-module, `ac_wdog`: a load/clear/enable counter with a `trip` output, parameterised by `TIMEOUT_CYC`.

## Test plan
- **Full frame, no stall.** `frame_start`, 96 symbols with `sym_valid` and `core_ready` held at 1, then `core_flush_done` 3 cycles after `core_flush`. Required:
  - 96 core transfers.
  - `core_last` only on the 96th.
  - `core_flush` pulses once.
  - `frame_done` pulses 1 cycle after `core_flush_done`.
  - `sym_count` = 96.
- **Core backpressure.** `core_ready` toggles 1-of-3 cycles. Required: symbol order is preserved, no symbol is lost or duplicated, and `sym_ready` = 0 whenever `core_valid && !core_ready`.
- **Watchdog, reduced timeout.** `TIMEOUT_CYC` = 8, `core_ready` stuck at 0 after symbol 5. Required:
  - `err_timeout` = 1 after exactly 8 stall cycles.
  - State ERR, `frame_busy` = 0.
  - `frame_abort` clears the flag and returns to IDLE.
- **Illegal symbol (macro defined).** Symbol 3'b110 injected at position 10. Required: `err_illegal` = 1, the symbol is not forwarded, the frame still completes with 96 forwarded symbols.
- **Abort and asynchronous reset mid-frame.** `frame_abort` at symbol 40, same cycle as `frame_start`. Required: IDLE next cycle, `core_valid` = 0, `sym_count` = 0. Then `sys_reset` low mid-frame: all outputs 0 immediately.
